// File: rtl/ch3_pkg.sv
// Shared types for the sr_latch button front end.
// FSM state encoding used by the pulse generator.
package ch3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R
  } sr_drv_state_t;

endpackage

// File: rtl/debouncer.sv
// One button channel: two-flop synchronizer, counter debouncer,
// and rising-edge detector on the debounced level.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_dly_q;

endmodule

// File: rtl/sr_button_driver.sv
// Turns two bouncy buttons into mutually exclusive, fixed-length
// set/reset pulses for the downstream sr_latch.
module sr_button_driver
  import ch3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic drop
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PLEN = PW'(PULSE_LEN);

  logic req_s, req_r;
  logic set_stable, rst_stable;

  sr_drv_state_t state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          conflict_q, conflict_d;
  logic          drop_q, drop_d;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk    (clk),
    .reset  (reset),
    .btn    (set_btn),
    .stable (set_stable),
    .rise   (req_s)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk    (clk),
    .reset  (reset),
    .btn    (rst_btn),
    .stable (rst_stable),
    .rise   (req_r)
  );

  // Debounced levels are only needed through their edges here.
  logic unused_stable;
  assign unused_stable = set_stable ^ rst_stable;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    s_d        = s_q;
    r_d        = r_q;
    conflict_d = 1'b0;
    drop_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && req_r) begin
          conflict_d = 1'b1;
        end else if (req_s) begin
          state_d = PULSE_S;
          s_d     = 1'b1;
          r_d     = 1'b0;
          pcnt_d  = PW'(1);
        end else if (req_r) begin
          state_d = PULSE_R;
          r_d     = 1'b1;
          s_d     = 1'b0;
          pcnt_d  = PW'(1);
        end
      end
      PULSE_S, PULSE_R: begin
        drop_d = req_s | req_r;
        if (pcnt_q == PLEN) begin
          state_d = IDLE;
          s_d     = 1'b0;
          r_d     = 1'b0;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
        pcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      drop_q     <= drop_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_sr_button_driver.sv
// Scoreboard bench for sr_button_driver with DEBOUNCE_CYCLES=4,
// PULSE_LEN=2; expected output events are queued by the stimulus.
module tb_sr_button_driver;

  localparam logic [3:0] EV_S = 4'b1000;
  localparam logic [3:0] EV_R = 4'b0100;
  localparam logic [3:0] EV_C = 4'b0010;
  localparam logic [3:0] EV_D = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic rst_btn;
  logic s, r, conflict, drop;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] v;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  sr_button_driver #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_LEN      (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_btn  (set_btn),
    .rst_btn  (rst_btn),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .drop     (drop)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push(input int c, input logic [3:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events pending, required 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic quiet(input string name);
    checks++;
    if ({s, r, conflict, drop} !== 4'b0000) begin
      errors++;
      $display("FAIL %s: srcd=%b, required 0000", name,
               {s, r, conflict, drop});
    end
  endtask

  ev_t        m_e;
  logic [3:0] m_v;

  always @(negedge clk) begin
    if (mon_en) begin
      m_v = {s, r, conflict, drop};
      checks++;
      if (s & r) begin
        errors++;
        $display("FAIL invariant: s&r=1 at cycle %0d, required 0", cyc);
      end
      if (m_v != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: srcd=%b at cycle %0d, required none",
                   m_v, cyc);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.c != cyc || m_e.v != m_v) begin
            errors++;
            $display("FAIL event: srcd=%b at cycle %0d, required %b at %0d",
                     m_v, cyc, m_e.v, m_e.c);
          end
        end
      end
    end
  end

  int k;

  initial begin
    reset   = 1'b1;
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(1);
    quiet("reset_state");
    step(1);
    reset  = 1'b0;
    mon_en = 1'b1;
    step(2);

    // clean press
    k = cyc;
    set_btn = 1'b1;
    push(k + 7, EV_S);
    push(k + 8, EV_S);
    step(12);
    set_btn = 1'b0;
    step(10);
    drain("clean_press");

    // bounce on rst_btn
    rst_btn = 1'b1; step(1);
    rst_btn = 1'b0; step(1);
    rst_btn = 1'b1; step(1);
    rst_btn = 1'b0; step(1);
    k = cyc;
    rst_btn = 1'b1;
    push(k + 7, EV_R);
    push(k + 8, EV_R);
    step(12);
    rst_btn = 1'b0;
    step(10);
    drain("bounce");

    // simultaneous press
    k = cyc;
    set_btn = 1'b1;
    rst_btn = 1'b1;
    push(k + 7, EV_C);
    step(12);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(10);
    drain("simultaneous");

    // overlap on first s cycle
    k = cyc;
    set_btn = 1'b1;
    push(k + 7, EV_S);
    push(k + 8, EV_S | EV_D);
    step(1);
    rst_btn = 1'b1;
    step(12);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(10);
    drain("overlap_first");

    // new edge in final pulse cycle
    k = cyc;
    set_btn = 1'b1;
    push(k + 7, EV_S);
    push(k + 8, EV_S);
    push(k + 9, EV_D);
    step(2);
    rst_btn = 1'b1;
    step(12);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    step(10);
    drain("overlap_last");

    // reset mid-pulse, button held
    k = cyc;
    set_btn = 1'b1;
    push(k + 7, EV_S);
    step(7);
    reset = 1'b1;
    step(1);
    quiet("reset_mid_pulse");
    reset = 1'b0;
    push(k + 15, EV_S);
    push(k + 16, EV_S);
    step(12);
    set_btn = 1'b0;
    step(10);
    drain("after_reset");

    // reset held while buttons pressed
    reset   = 1'b1;
    set_btn = 1'b1;
    step(10);
    quiet("reset_held");
    set_btn = 1'b0;
    rst_btn = 1'b1;
    step(8);
    rst_btn = 1'b0;
    step(2);
    reset = 1'b0;
    step(10);
    drain("reset_held");

    // 3-cycle glitch
    set_btn = 1'b1;
    step(3);
    set_btn = 1'b0;
    step(12);
    drain("glitch");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
